// File: rtl/ex_muldiv.sv
// ex_muldiv: iterative RV32M multiply/divide unit that stalls EX until its result is ready
module ex_muldiv #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            valid_i,
    input  logic [2:0]      funct3_i,
    input  logic [XLEN-1:0] rs1_i,
    input  logic [XLEN-1:0] rs2_i,
    input  logic [4:0]      wd_i,
    input  logic            wreg_i,
    output logic            stallreq_o,
    output logic            done_o,
    output logic [XLEN-1:0] result_o,
    output logic [4:0]      wd_o,
    output logic            wreg_o
);
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
    localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};
    state_t state, state_nx;
    logic [CNT_W-1:0] cnt;
    logic [2:0] op;
    logic [4:0] wd_r;
    logic wreg_r, neg;
    logic s1, s2, n1, n2, special, ge, last;
    logic [XLEN-1:0] b, m1, m2, sp_res, diff, q, fin;
    logic [XLEN:0] sum, trial;
    logic [2*XLEN-1:0] acc, acc_nx, prod;
    always_comb begin
        s1 = funct3_i[2] ? !funct3_i[0] : funct3_i[1:0] != 2'b11;
        s2 = funct3_i[2] ? !funct3_i[0] : !funct3_i[1];
        n1 = s1 && rs1_i[XLEN-1];
        n2 = s2 && rs2_i[XLEN-1];
        m1 = n1 ? -rs1_i : rs1_i;
        m2 = n2 ? -rs2_i : rs2_i;
        special = funct3_i[2] && (rs2_i == '0 || (!funct3_i[0] && rs1_i == MIN_INT && rs2_i == '1));
        sp_res = rs2_i == '0 ? (funct3_i[1] ? rs1_i : '1) : (funct3_i[1] ? '0 : MIN_INT);
        last = cnt == CNT_W'(XLEN - 1);
        // multiply: shift-add, acc = {partial product, remaining multiplier bits}
        sum = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, b} : '0);
        // divide: restoring, acc = {partial remainder, dividend/quotient bits}
        trial = acc[2*XLEN-1:XLEN-1];
        ge = trial >= {1'b0, b};
        diff = trial[XLEN-1:0] - b;
        acc_nx = op[2] ? (ge ? {diff, acc[XLEN-2:0], 1'b1} : {trial[XLEN-1:0], acc[XLEN-2:0], 1'b0})
                       : {sum, acc[XLEN-1:1]};
        prod = neg ? -acc_nx : acc_nx;
        q = op[1] ? acc_nx[2*XLEN-1:XLEN] : acc_nx[XLEN-1:0];
        fin = op[2] ? (neg ? -q : q) : (op[1:0] == 2'b00 ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN]);
        state_nx = state == IDLE ? (valid_i ? (special ? DONE : CALC) : IDLE)
                 : state == CALC ? (last ? DONE : CALC) : IDLE;
    end
    assign stallreq_o = (state == IDLE && valid_i) || state == CALC;
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else state <= state_nx;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
            op <= '0;
            wd_r <= '0;
            wreg_r <= 1'b0;
            neg <= 1'b0;
            b <= '0;
            acc <= '0;
            done_o <= 1'b0;
            result_o <= '0;
            wd_o <= '0;
            wreg_o <= 1'b0;
        end else begin
            done_o <= state_nx == DONE;
            result_o <= '0;
            wd_o <= '0;
            wreg_o <= 1'b0;
            if (state == IDLE && valid_i) begin
                op <= funct3_i;
                wd_r <= wd_i;
                wreg_r <= wreg_i;
                neg <= (funct3_i[2] && funct3_i[1]) ? n1 : n1 ^ n2;
                cnt <= '0;
                b <= funct3_i[2] ? m2 : m1;
                acc <= {{XLEN{1'b0}}, funct3_i[2] ? m1 : m2};
                if (special) begin
                    result_o <= sp_res;
                    wd_o <= wd_i;
                    wreg_o <= wreg_i;
                end
            end
            if (state == CALC) begin
                acc <= acc_nx;
                cnt <= cnt + 1'b1;
                if (last) begin
                    result_o <= fin;
                    wd_o <= wd_r;
                    wreg_o <= wreg_r;
                end
            end
        end
    end
endmodule

// File: tb/tb_ex_muldiv.sv
// tb_ex_muldiv: directed and random checks of ex_muldiv against an arithmetic reference model
module tb_ex_muldiv;
    logic clk = 0, rst = 1, valid = 0, wreg = 0;
    logic [2:0] funct3 = 0;
    logic [31:0] rs1 = 0, rs2 = 0;
    logic [4:0] wd = 0;
    logic stallreq, done, wreg_out;
    logic [31:0] result;
    logic [4:0] wd_out;
    int checks = 0, errors = 0;

    ex_muldiv dut (
        .clk(clk), .rst(rst), .valid_i(valid), .funct3_i(funct3), .rs1_i(rs1), .rs2_i(rs2),
        .wd_i(wd), .wreg_i(wreg), .stallreq_o(stallreq), .done_o(done), .result_o(result),
        .wd_o(wd_out), .wreg_o(wreg_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, ub;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ub = longint'({32'b0, b});
        case (f)
            3'd0: begin p = sa * sb; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
            3'd4: return b == 0 ? 32'hFFFFFFFF : 32'(sa / sb);
            3'd5: return b == 0 ? 32'hFFFFFFFF : a / b;
            3'd6: return b == 0 ? a : 32'(sa % sb);
            default: return b == 0 ? a : a % b;
        endcase
    endfunction

    task automatic run(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] d, input logic w, input logic hold);
        int stalls, cyc, lat;
        logic [31:0] exp;
        stalls = 0;
        cyc = 0;
        exp = model(f, a, b);
        lat = (f[2] && (b == 0 || (!f[0] && a == 32'h80000000 && b == 32'hFFFFFFFF))) ? 1 : 33;
        valid = 1; funct3 = f; rs1 = a; rs2 = b; wd = d; wreg = w;
        #1;
        check("start_no_done", done, 0);
        while (!done && cyc < 100) begin
            if (stallreq) stalls++;
            @(negedge clk); #1;
            cyc++;
        end
        check("done_seen", done, 1);
        check("stall_cycles", stalls, lat);
        check("result", result, exp);
        check("wd", wd_out, d);
        check("wreg", wreg_out, w);
        check("stall_at_done", stallreq, 0);
        valid = hold;
        @(negedge clk); #1;
        check("done_one_cycle", done, 0);
    endtask

    initial begin
        int pulses;
        logic [2:0] f;
        logic [31:0] a, b;
        logic [4:0] d;
        logic w;
        repeat (3) @(negedge clk);
        #1;
        check("rst_done", done, 0);
        check("rst_result", result, 0);
        check("rst_wd", wd_out, 0);
        check("rst_wreg", wreg_out, 0);
        check("rst_stall", stallreq, 0);
        rst = 0;
        @(negedge clk);
        run(3'd0, 32'd7, 32'd6, 5'd9, 1'b1, 1'b0);
        run(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd1, 1'b1, 1'b0);
        run(3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd2, 1'b0, 1'b0);
        run(3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd3, 1'b1, 1'b0);
        run(3'd4, 32'hFFFFFFF9, 32'd2, 5'd4, 1'b1, 1'b0);
        run(3'd6, 32'hFFFFFFF9, 32'd2, 5'd5, 1'b1, 1'b0);
        run(3'd5, 32'd100, 32'd7, 5'd6, 1'b1, 1'b0);
        run(3'd7, 32'd100, 32'd7, 5'd7, 1'b1, 1'b0);
        run(3'd5, 32'd5, 32'd0, 5'd8, 1'b1, 1'b0);
        run(3'd6, 32'h80000000, 32'hFFFFFFFF, 5'd10, 1'b1, 1'b0);
        run(3'd4, 32'h80000000, 32'hFFFFFFFF, 5'd11, 1'b1, 1'b1);
        run(3'd0, 32'hFFFFFFFD, 32'd5, 5'd12, 1'b1, 1'b1);
        run(3'd7, 32'd9, 32'd0, 5'd13, 1'b1, 1'b1);
        run(3'd4, 32'd12345, 32'hFFFFFFFB, 5'd14, 1'b1, 1'b0);
        for (int i = 0; i < 24; i++) begin
            f = 3'($urandom_range(0, 7));
            a = $urandom;
            b = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
            if ($urandom_range(0, 3) == 0) b = 32'($urandom_range(1, 50));
            d = 5'($urandom);
            w = 1'($urandom);
            run(f, a, b, d, w, i % 3 == 0);
        end
        valid = 0;
        @(negedge clk);
        valid = 1; funct3 = 3'd0; rs1 = $urandom; rs2 = $urandom; wd = 5'd3; wreg = 1;
        @(negedge clk);
        repeat (10) @(negedge clk);
        rst = 1;
        valid = 0;
        @(negedge clk); #1;
        check("abort_stall_idle", stallreq, 0);
        check("abort_done", done, 0);
        valid = 1;
        #1;
        check("abort_stall_valid", stallreq, 1);
        valid = 0;
        rst = 0;
        pulses = 0;
        repeat (40) begin
            @(negedge clk); #1;
            if (done) pulses++;
        end
        check("abort_no_done", pulses, 0);
        run(3'd7, 32'd100, 32'd7, 5'd15, 1'b1, 1'b0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/ex_muldiv.md
Name: ex_muldiv

Overview:
- Iterative RV32M multiply/divide unit in the EX stage.
- Consumes the operands and destination held in the ID/EX pipeline register.
- Holds the pipeline through the EX stall request until the result is ready, then presents result and writeback control to the EX/MEM path for exactly one cycle.
- One operation in flight at a time.

Parameters:
XLEN, 32, operand/result width
CNT_W, 5, iteration counter width (log2 XLEN)

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
valid_i  in  1  ID/EX holds an M-extension instruction
funct3_i  in  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
rs1_i  in  XLEN  operand 1 (multiplicand/dividend)
rs2_i  in  XLEN  operand 2 (multiplier/divisor)
wd_i  in  5  destination register address
wreg_i  in  1  write-enable from decode
stallreq_o  out  1  EX stall request (freezes stages up to and including ID/EX)
done_o  out  1  result valid this cycle
result_o  out  XLEN  result
wd_o  out  5  destination address accompanying result
wreg_o  out  1  write-enable accompanying result

Behaviour:
- Reset (rst=1 at clk edge): state=IDLE, counter=0, all internal registers 0, done_o=0, result_o=0, wd_o=0, wreg_o=0.
- stallreq_o is combinational: (state==IDLE && valid_i) || state==CALC.
- Inputs are guaranteed stable while stallreq_o=1, because ID/EX holds its contents.
- States: IDLE, CALC, DONE.
- IDLE:
  - valid_i=0: stay in IDLE.
  - valid_i=1, special case: compute result directly, go to DONE.
  - valid_i=1, otherwise: latch funct3, wd, wreg, |rs1|, |rs2| (magnitude only for signed operands), the result sign, and the dividend sign; clear counter; go to CALC.
- Special cases (no CALC, 2-cycle total):
  - divisor 0: DIV/DIVU → all ones; REM/REMU → rs1.
  - DIV/REM with rs1=0x80000000, rs2=0xFFFFFFFF: DIV → 0x80000000; REM → 0.
- CALC:
  - Multiply: shift-add, one multiplier bit per cycle into a 2·XLEN accumulator.
  - Divide: restoring division, one quotient bit per cycle.
  - Counter increments each cycle; when counter==XLEN-1, go to DONE next cycle.
  - CALC lasts exactly XLEN cycles.
- DONE:
  - done_o=1, stallreq_o=0; result_o, wd_o, wreg_o valid.
  - Next state is IDLE unconditionally; valid_i is ignored here so the same instruction does not restart.
  - Outside DONE: done_o=0, wreg_o=0; result_o and wd_o are don't-care and are held at 0.
- Result selection (unsigned magnitude result R; negate when the result sign is set):
  - MUL: low XLEN bits of product.
  - MULH/MULHSU/MULHU: high XLEN bits.
  - MULHSU: rs1 signed, rs2 unsigned.
  - DIV/DIVU: quotient. REM/REMU: remainder.
  - Remainder sign follows the dividend.
  - Product negation is applied on the full 2·XLEN value before slicing.
- Latency: normal op occupies EX for XLEN+2 cycles (IDLE accept, XLEN CALC cycles, DONE), with stall asserted for XLEN+1 cycles.
- A branch flush never targets the instruction in EX, so no kill input exists.
- rst mid-CALC aborts the operation immediately; no done_o is produced.
- valid_i dropping during CALC: operation continues on latched values (non-conforming stimulus, but defined).

Test Plan:
- MUL rs1=7, rs2=6 → stallreq_o high 33 cycles, then done_o=1 for one cycle, result_o=42, wd_o/wreg_o echo the inputs.
- MULH rs1=0xFFFFFFFF (-1), rs2=0xFFFFFFFF → result_o=0; MULHU same operands → 0xFFFFFFFE; MULHSU same operands → 0xFFFFFFFF.
- DIV rs1=-7 (0xFFFFFFF9), rs2=2 → result_o=0xFFFFFFFD (-3); REM same operands → 0xFFFFFFFF (-1); DIVU 100/7 → 14; REMU 100/7 → 2.
- DIVU rs1=5, rs2=0 → 0xFFFFFFFF, done one cycle after accept (stall 1 cycle); REM rs1=0x80000000, rs2=0xFFFFFFFF → 0.
- Back-to-back ops: valid_i held through DONE with new operands presented the cycle after DONE → exactly one result per instruction, no duplicate start.
- rst asserted at CALC cycle 10 → next cycle state IDLE, stallreq_o=valid_i, done_o never pulses for the aborted op.
